// File: rtl/enc_pkg.sv
// Shared state type, default sizing and helpers for the one-hot stream encoder.
package enc_pkg;

  localparam int unsigned ENC_WIDTH  = 8;
  localparam int unsigned ENC_CODE_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // True when at most one bit of vec is set.
  function automatic logic is_single(input logic [ENC_WIDTH-1:0] vec);
    return (vec & (vec - ENC_WIDTH'(1))) == '0;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational priority encoder: index of the lowest (or highest) set bit plus an any-bit flag.
// Index is 0 when no bit is set.
module prio_enc8
  import enc_pkg::*;
#(
  parameter int unsigned WIDTH     = ENC_WIDTH,
  parameter int unsigned CODE_W    = ENC_CODE_W,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic [WIDTH-1:0]  i_vec,
  output logic [CODE_W-1:0] o_idx,
  output logic              o_any
);

  // The last matching assignment wins, so loop direction sets the priority.
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (i_vec[i]) o_idx = CODE_W'(i);
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (i_vec[i]) o_idx = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/onehot_stream_encoder.sv
// Streams the index code of every set bit of an accepted request vector, one beat per cycle.
// Define ENC_MSB_FIRST_EN to emit the highest set bit first instead of the lowest.
module onehot_stream_encoder
  import enc_pkg::*;
#(
  parameter int unsigned WIDTH  = ENC_WIDTH,
  parameter int unsigned CODE_W = ENC_CODE_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [WIDTH-1:0]  i_in_vec,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CODE_W-1:0] o_out_code,
  output logic              o_out_last,
  output logic              o_zero_seen
);

`ifdef ENC_MSB_FIRST_EN
  localparam bit MsbFirst = 1'b1;
`else
  localparam bit MsbFirst = 1'b0;
`endif

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WIDTH-1:0]  r_pending;
  logic [WIDTH-1:0]  w_pending_nxt;
  logic [WIDTH-1:0]  w_sel;
  logic              r_zero_seen;
  logic [CODE_W-1:0] w_idx;
  logic              w_any;
  logic              w_last;
  logic              w_beat;
  logic              w_accept;

  prio_enc8 #(
    .WIDTH    (WIDTH),
    .CODE_W   (CODE_W),
    .MSB_FIRST(MsbFirst)
  ) u_prio (
    .i_vec(r_pending),
    .o_idx(w_idx),
    .o_any(w_any)
  );

  // pending is zero whenever the block is idle, so w_any gates out_last off in IDLE.
  assign w_last      = w_any & is_single(r_pending);
  assign w_sel       = {{(WIDTH-1){1'b0}}, 1'b1} << w_idx;
  assign o_out_valid = (r_state == EMIT);
  assign o_out_code  = w_idx;
  assign o_out_last  = w_last;
  assign o_zero_seen = r_zero_seen;
  assign w_beat      = o_out_valid & i_out_ready;
  assign o_in_ready  = ~i_rst & ((r_state == IDLE) | (w_beat & w_last));
  assign w_accept    = i_in_valid & o_in_ready;

  always_comb begin
    w_pending_nxt = r_pending;
    w_state_nxt   = r_state;
    if (w_beat) begin
      w_pending_nxt = r_pending & ~w_sel;
      if (w_last) w_state_nxt = IDLE;
    end
    // A nonzero vector handed off on the last beat reloads with no bubble.
    if (w_accept && (i_in_vec != '0)) begin
      w_pending_nxt = i_in_vec;
      w_state_nxt   = EMIT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_zero_seen <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_zero_seen <= w_accept & (i_in_vec == '0);
    end
  end

endmodule

// File: tb/tb_onehot_stream_encoder.sv
// Self-checking bench for onehot_stream_encoder: directed scenarios plus randomized traffic
// checked against a queue-of-codes reference model. Honours ENC_MSB_FIRST_EN.
module tb_onehot_stream_encoder;

  localparam int W  = 8;
  localparam int CW = 3;

`ifdef ENC_MSB_FIRST_EN
  localparam logic [31:0] EXP_2C    = 32'h0000_0A35;
  localparam logic [31:0] EXP_90    = 32'h0000_00C7;
  localparam logic [31:0] EXP_FF    = 32'h8123_4567;
  localparam int          STALL_CODE = 7;
`else
  localparam logic [31:0] EXP_2C    = 32'h0000_0D32;
  localparam logic [31:0] EXP_90    = 32'h0000_00F4;
  localparam logic [31:0] EXP_FF    = 32'hF654_3210;
  localparam int          STALL_CODE = 4;
`endif
  localparam logic [31:0] EXP_B2B = 32'h0000_00F8;
  localparam logic [31:0] EXP_04  = 32'h0000_000A;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_vec = '0;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_code;
  logic          out_last;
  logic          zero_seen;

  always #5 clk = ~clk;

  onehot_stream_encoder #(
    .WIDTH (W),
    .CODE_W(CW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_vec   (in_vec),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_code (out_code),
    .o_out_last (out_last),
    .o_zero_seen(zero_seen)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: codes still owed for accepted vectors, in emission order.
  int         exp_q[$];
  bit         zero_exp = 1'b0;
  bit         mon_en = 1'b0;
  logic [3:0] log_q[$];  // observed beats as {last, code}
  bit         rand_ready = 1'b0;

  function automatic void push_vec(input logic [W-1:0] v);
`ifdef ENC_MSB_FIRST_EN
    for (int i = W - 1; i >= 0; i--) if (v[i]) exp_q.push_back(i);
`else
    for (int i = 0; i < W; i++) if (v[i]) exp_q.push_back(i);
`endif
  endfunction

  function automatic logic [31:0] pack_log();
    logic [31:0] r = '0;
    for (int i = 0; i < log_q.size() && i < 8; i++) r |= 32'(log_q[i]) << (4 * i);
    return r;
  endfunction

  // Inputs change just after posedge; everything is compared here, mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_rdy;
      exp_rdy = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready));
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("out_code", out_code, exp_q[0]);
        check("out_last", out_last, exp_q.size() == 1);
      end
      check("zero_seen", zero_seen, zero_exp);
      check("in_ready", in_ready, exp_rdy);
      if (rst) begin
        exp_q.delete();
        zero_exp = 1'b0;
      end else begin
        zero_exp = 1'b0;
        if (out_valid && out_ready && exp_q.size() != 0) begin
          log_q.push_back({out_last, out_code});
          void'(exp_q.pop_front());
        end
        if (in_valid && exp_rdy) begin
          if (in_vec == '0) zero_exp = 1'b1;
          else push_vec(in_vec);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Presents v until accepted; returns just after the accepting edge with in_valid still high.
  task automatic send(input logic [W-1:0] v);
    int guard = 0;
    in_valid = 1'b1;
    in_vec   = v;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while ((exp_q.size() != 0 || out_valid) && guard < 300);
    if (exp_q.size() != 0 || out_valid) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_code", out_code, 0);
    check("rst_out_last", out_last, 0);
    check("rst_zero_seen", zero_seen, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // 0x2C at full throughput
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    log_q.delete();
    send(8'h2C);
    in_valid = 1'b0;
    wait_idle();
    check("v2c_beats", log_q.size(), 3);
    check("v2c_codes", pack_log(), EXP_2C);

    // 0x90 under backpressure
    out_ready = 1'b0;
    log_q.delete();
    send(8'h90);
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_code", out_code, STALL_CODE);
      check("stall_last", out_last, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    check("v90_codes", pack_log(), EXP_90);

    // Back-to-back single-bit vectors
    log_q.delete();
    send(8'h01);
    send(8'h80);
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_no_bubble", out_valid, 1);
    wait_idle();
    check("b2b_codes", pack_log(), EXP_B2B);

    // Zero vector, then full vector
    send(8'h00);
    in_valid = 1'b0;
    check("zero_pulse", zero_seen, 1);
    check("zero_no_beat", out_valid, 0);
    @(posedge clk);
    #1;
    check("zero_pulse_end", zero_seen, 0);
    log_q.delete();
    send(8'hFF);
    in_valid = 1'b0;
    wait_idle();
    check("vff_beats", log_q.size(), 8);
    check("vff_codes", pack_log(), EXP_FF);

    // Reset in the middle of a full burst, after the third beat
    log_q.delete();
    send(8'hFF);
    in_valid = 1'b0;
    for (int g = 0; g < 50 && log_q.size() < 3; g++) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_beats", log_q.size(), 3);
    check("midrst_valid", out_valid, 0);
    check("midrst_code", out_code, 0);
    check("midrst_last", out_last, 0);
    log_q.delete();
    send(8'h04);
    in_valid = 1'b0;
    wait_idle();
    check("v04_codes", pack_log(), EXP_04);
    check("v04_beats", log_q.size(), 1);

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      int           gap;
      logic [W-1:0] v;
      gap = $urandom_range(0, 3);
      v   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if (gap != 0) begin
        in_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      send(v);
    end
    in_valid = 1'b0;
    wait_idle();
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
